// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU, the round-robin arbiter and the
// wrapper that shares one ALU between two requesters.
//   - CMD_* : 4-bit ALU command codes; codes above CMD_MAX are illegal.
//   - arb_state_e : states of the sharing FSM (also exposed for debug).
//   - cmd_is_legal() : true for the codes the ALU implements.
package alu_pkg;

  localparam logic [3:0] CMD_AND   = 4'h0;
  localparam logic [3:0] CMD_OR    = 4'h1;
  localparam logic [3:0] CMD_XOR   = 4'h2;
  localparam logic [3:0] CMD_NOT   = 4'h3;
  localparam logic [3:0] CMD_UADD  = 4'h4;
  localparam logic [3:0] CMD_SADD  = 4'h5;
  localparam logic [3:0] CMD_USUB  = 4'h6;
  localparam logic [3:0] CMD_SSUB  = 4'h7;
  localparam logic [3:0] CMD_UMUL  = 4'h8;
  localparam logic [3:0] CMD_SMUL  = 4'h9;
  localparam logic [3:0] CMD_UCMP  = 4'hA;
  localparam logic [3:0] CMD_SCMP  = 4'hB;
  localparam logic [3:0] CMD_SHIFT = 4'hC;
  localparam logic [3:0] CMD_MAX   = 4'hC;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  function automatic logic cmd_is_legal(input logic [3:0] cmd);
    return (cmd <= CMD_MAX);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request and response channels of the shared ALU.
//   req_valid[i]/req_ready[i] : requester i handshake; cmd/a/b per requester.
//   rsp_valid/rsp_ready       : response handshake; id/result/overflow/err.
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high. Once valid is raised the sender keeps
// valid and its payload stable until that edge. The receiver may raise ready
// at any time; ready may depend combinationally on valid.
interface alu_arbiter_if #(
  parameter int SIZE = 4
);
  localparam int FULL_SIZE = 2 * SIZE;

  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [3:0]           req_cmd0;
  logic [3:0]           req_cmd1;
  logic [SIZE-1:0]      req_a0;
  logic [SIZE-1:0]      req_a1;
  logic [SIZE-1:0]      req_b0;
  logic [SIZE-1:0]      req_b1;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic [FULL_SIZE-1:0] rsp_result;
  logic                 rsp_overflow;
  logic                 rsp_err;

  // Requesters plus the downstream response consumer.
  modport master (
    output req_valid, req_cmd0, req_cmd1, req_a0, req_a1, req_b0, req_b1,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_err
  );

  // The arbiter.
  modport slave (
    input  req_valid, req_cmd0, req_cmd1, req_a0, req_a1, req_b0, req_b1,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_err
  );
endinterface

// File: rtl/alu.sv
// alu: combinational ALU, SIZE-bit operands, 2*SIZE-bit result.
//   enable   in  : when low, result and overflow are forced to 0.
//   command  in  : CMD_* code; illegal codes give 0/0.
//   a, b     in  : operands.
//   result   out : full-width result (signed ops are sign-extended).
//   overflow out : result does not fit back into SIZE bits (per operation).
// Compare ops return {gt, eq, lt} in the low three bits.
// Shift returns a << b; overflow flags bits shifted above SIZE.
module alu
  import alu_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic              enable,
  input  logic [3:0]        command,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic [2*SIZE-1:0] result,
  output logic              overflow
);
  localparam int FULL_SIZE = 2 * SIZE;

  logic [FULL_SIZE-1:0] ua, ub, sa, sb;

  assign ua = {{SIZE{1'b0}}, a};
  assign ub = {{SIZE{1'b0}}, b};
  assign sa = {{SIZE{a[SIZE-1]}}, a};
  assign sb = {{SIZE{b[SIZE-1]}}, b};

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    if (enable) begin
      case (command)
        CMD_AND: result = ua & ub;
        CMD_OR:  result = ua | ub;
        CMD_XOR: result = ua ^ ub;
        CMD_NOT: result = {{SIZE{1'b0}}, ~a};
        CMD_UADD: begin
          result   = ua + ub;
          overflow = result[SIZE];
        end
        CMD_SADD: begin
          result   = sa + sb;
          overflow = (a[SIZE-1] == b[SIZE-1]) && (result[SIZE-1] != a[SIZE-1]);
        end
        CMD_USUB: begin
          result   = ua - ub;
          overflow = (a < b);
        end
        CMD_SSUB: begin
          result   = sa - sb;
          overflow = (a[SIZE-1] != b[SIZE-1]) && (result[SIZE-1] != a[SIZE-1]);
        end
        CMD_UMUL: begin
          result   = ua * ub;
          overflow = |result[FULL_SIZE-1:SIZE];
        end
        CMD_SMUL: begin
          // Low FULL_SIZE bits of the sign-extended product are the exact
          // signed product; it fits SIZE bits only if the top bits agree.
          result   = sa * sb;
          overflow = !((&result[FULL_SIZE-1:SIZE-1]) || !(|result[FULL_SIZE-1:SIZE-1]));
        end
        CMD_UCMP: begin
          result[0] = (a < b);
          result[1] = (a == b);
          result[2] = (a > b);
        end
        CMD_SCMP: begin
          result[0] = ($signed(a) < $signed(b));
          result[1] = (a == b);
          result[2] = ($signed(a) > $signed(b));
        end
        CMD_SHIFT: begin
          result   = ua << b;
          overflow = |result[FULL_SIZE-1:SIZE];
        end
        default: begin
          result   = '0;
          overflow = 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter2: combinational two-way round-robin grant.
//   req_valid_i  in  : request bit per requester.
//   rr_last_i    in  : requester granted most recently.
//   grant_valid_o out: some request is present.
//   grant_id_o    out: winning requester; on a tie, the one not in rr_last_i.
module rr_arbiter2 (
  input  logic [1:0] req_valid_i,
  input  logic       rr_last_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);
  always_comb begin
    grant_valid_o = |req_valid_i;
    grant_id_o    = 1'b0;
    case (req_valid_i)
      2'b01:   grant_id_o = 1'b0;
      2'b10:   grant_id_o = 1'b1;
      2'b11:   grant_id_o = ~rr_last_i;
      default: grant_id_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   clk, reset    : clock and asynchronous active-high reset.
//   bus (slave)   : request channels in, response channel out.
//   dbg_state_o   : current FSM state.
//   dbg_alu_en_o  : ALU enable (high only in EXEC with a legal command).
// Flow: IDLE grants one request (round-robin on ties) and latches it, EXEC
// runs the ALU for one cycle and registers its outputs, RESP holds the
// response until rsp_ready. One operation per three cycles at best.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic        clk,
  input  logic        reset,
  alu_arbiter_if.slave bus,
  output arb_state_e  dbg_state_o,
  output logic        dbg_alu_en_o
);
  localparam int FULL_SIZE = 2 * SIZE;

  arb_state_e           state_q;
  logic                 rr_last_q;
  logic [3:0]           cmd_q;
  logic [SIZE-1:0]      a_q, b_q;
  logic                 id_q;
  logic                 rsp_valid_q;
  logic                 rsp_id_q;
  logic [FULL_SIZE-1:0] rsp_result_q;
  logic                 rsp_overflow_q;
  logic                 rsp_err_q;

  logic                 grant_valid, grant_id, accept;
  logic [1:0]           req_ready;
  logic [3:0]           sel_cmd;
  logic [SIZE-1:0]      sel_a, sel_b;
  logic                 alu_en;
  logic [FULL_SIZE-1:0] alu_result;
  logic                 alu_ovf;

  rr_arbiter2 u_rr (
    .req_valid_i   (bus.req_valid),
    .rr_last_i     (rr_last_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  // Requests are only looked at in IDLE; elsewhere requesters must wait.
  assign accept = (state_q == ARB_IDLE) && grant_valid;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  assign sel_cmd = grant_id ? bus.req_cmd1 : bus.req_cmd0;
  assign sel_a   = grant_id ? bus.req_a1   : bus.req_a0;
  assign sel_b   = grant_id ? bus.req_b1   : bus.req_b0;

  // Illegal commands keep the ALU disabled, so its 0/0 outputs become the
  // response payload without any extra muxing.
  assign alu_en = (state_q == ARB_EXEC) && cmd_is_legal(cmd_q);

  alu #(.SIZE(SIZE)) u_alu (
    .enable   (alu_en),
    .command  (cmd_q),
    .a        (a_q),
    .b        (b_q),
    .result   (alu_result),
    .overflow (alu_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ARB_IDLE;
      rr_last_q      <= 1'b1;
      cmd_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      id_q           <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_err_q      <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (accept) begin
            cmd_q     <= sel_cmd;
            a_q       <= sel_a;
            b_q       <= sel_b;
            id_q      <= grant_id;
            rr_last_q <= grant_id;
            state_q   <= ARB_EXEC;
          end
        end
        ARB_EXEC: begin
          rsp_result_q   <= alu_result;
          rsp_overflow_q <= alu_ovf;
          rsp_err_q      <= !cmd_is_legal(cmd_q);
          rsp_id_q       <= id_q;
          rsp_valid_q    <= 1'b1;
          state_q        <= ARB_RESP;
        end
        ARB_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_err      = rsp_err_q;
  assign dbg_state_o      = state_q;
  assign dbg_alu_en_o     = alu_en;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter (SIZE=4): directed scenarios plus a randomized phase,
// all responses checked against a behavioural model of the ALU and the
// round-robin/handshake timing. Inputs change #1 after posedge, outputs are
// sampled on negedge.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int SIZE = 4;
  localparam int W    = 11; // {id, err, ovf, result[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_r;
  always #5 clk = ~clk;

  alu_arbiter_if #(.SIZE(SIZE)) bus ();
  arb_state_e dbg_state;
  logic       dbg_alu_en;

  alu_arbiter #(.SIZE(SIZE)) dut (
    .clk          (clk),
    .reset        (reset_r),
    .bus          (bus),
    .dbg_state_o  (dbg_state),
    .dbg_alu_en_o (dbg_alu_en)
  );

  logic       v0, v1, rsp_ready_r;
  logic [3:0] c0, c1, a0, a1, b0, b1;

  assign bus.req_valid = {v1, v0};
  assign bus.req_cmd0  = c0;
  assign bus.req_cmd1  = c1;
  assign bus.req_a0    = a0;
  assign bus.req_a1    = a1;
  assign bus.req_b0    = b0;
  assign bus.req_b1    = b1;
  assign bus.rsp_ready = rsp_ready_r;

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_op(input bit id, input logic [3:0] cmd,
                                            input logic [3:0] a, input logic [3:0] b);
    int ua, ub, sa, sb, r;
    bit ovf, err;
    ua = int'(a); ub = int'(b);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    r = 0; ovf = 0; err = 0;
    case (cmd)
      4'h0: r = int'(a & b);
      4'h1: r = int'(a | b);
      4'h2: r = int'(a ^ b);
      4'h3: r = (15 - ua);
      4'h4: begin r = ua + ub; ovf = (r > 15); end
      4'h5: begin r = sa + sb; ovf = (r > 7) || (r < -8); end
      4'h6: begin r = ua - ub; ovf = (ua < ub); end
      4'h7: begin r = sa - sb; ovf = (r > 7) || (r < -8); end
      4'h8: begin r = ua * ub; ovf = (r > 15); end
      4'h9: begin r = sa * sb; ovf = (r > 7) || (r < -8); end
      4'hA: r = (ua < ub) ? 1 : ((ua == ub) ? 2 : 4);
      4'hB: r = (sa < sb) ? 1 : ((sa == sb) ? 2 : 4);
      4'hC: begin r = (ua << ub) & 255; ovf = (r > 15); end
      default: err = 1;
    endcase
    r = r & 255;
    return {id, err, ovf, r[7:0]};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rsp_log[$];
  int           grant_log[$];
  bit           busy;
  bit           last;
  int           age;
  int           cyc = 0;
  int           dut_req_cyc = 0;
  int           dut_rsp_cyc = 0;

  always @(negedge clk) begin
    if (reset_r) begin
      exp_q.delete();
      busy = 0;
      age  = 0;
      last = 1;
    end else begin
      logic [1:0] vld, exp_rdy;
      bit         exp_rv, exp_en, g;
      cyc++;
      vld = {v1, v0};
      if (busy) age++;
      exp_rv = busy && (age >= 2);
      exp_en = busy && (age == 1) && (exp_q.size() > 0) && !exp_q[0][9];
      if (busy)              exp_rdy = 2'b00;
      else if (vld == 2'b11) exp_rdy = last ? 2'b01 : 2'b10;
      else                   exp_rdy = vld;

      check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      check("alu_enable", 32'(dbg_alu_en), 32'(exp_en));
      if (exp_rv && bus.rsp_valid && exp_q.size() > 0)
        check("rsp_payload",
              32'({bus.rsp_id, bus.rsp_err, bus.rsp_overflow, bus.rsp_result}),
              32'(exp_q[0]));

      // Logs of what the DUT actually did, used by directed checks.
      if (|(vld & bus.req_ready)) begin
        grant_log.push_back(int'(bus.req_ready[1]));
        dut_req_cyc = cyc;
      end
      if (bus.rsp_valid && rsp_ready_r) begin
        rsp_log.push_back({bus.rsp_id, bus.rsp_err, bus.rsp_overflow, bus.rsp_result});
        dut_rsp_cyc = cyc;
      end

      // Model advance for the coming edge.
      if (exp_rv && rsp_ready_r) begin
        void'(exp_q.pop_front());
        busy = 0;
      end else if (!busy && exp_rdy != 2'b00) begin
        g = exp_rdy[1];
        exp_q.push_back(model_op(g, g ? c1 : c0, g ? a1 : a0, g ? b1 : b0));
        last = g;
        busy = 1;
        age  = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bit i, input logic [3:0] cmd, input logic [3:0] a, input logic [3:0] b);
    if (i == 1'b0) begin c0 = cmd; a0 = a; b0 = b; v0 = 1'b1; end
    else           begin c1 = cmd; a1 = a; b1 = b; v1 = 1'b1; end
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!reset_r && bus.req_ready[i]) begin
        @(posedge clk); #1;
        if (i == 1'b0) v0 = 1'b0; else v1 = 1'b0;
        return;
      end
    end
    check($sformatf("req%0d_timeout", i), 32'd0, 32'd1);
    if (i == 1'b0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic send_rand(input bit i);
    send(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (!busy && !bus.rsp_valid) return;
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    reset_r = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_r = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  bit s0_done;
  bit rand_done;
  int gap;

  initial begin
    v0 = 0; v1 = 0; c0 = 0; c1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0;
    rsp_ready_r = 1'b1;
    reset_r = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    check("rst_rsp_ovf", 32'(bus.rsp_overflow), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
    reset_r = 1'b0;
    @(posedge clk); #1;

    // Single request: AND A,5 -> 0.
    rsp_log.delete();
    send(1'b0, CMD_AND, 4'hA, 4'h5);
    wait_idle();
    check("single_count", 32'(rsp_log.size()), 32'd1);
    if (rsp_log.size() > 0) check("single_rsp", 32'(rsp_log[0]), 32'({1'b0, 1'b0, 1'b0, 8'h00}));
    check("single_latency", 32'(dut_rsp_cyc - dut_req_cyc), 32'd2);

    // Contention from reset, then both held valid.
    pulse_reset();
    rsp_log.delete();
    grant_log.delete();
    fork
      begin send(1'b0, CMD_UMUL, 4'h7, 4'h8); repeat (3) send_rand(1'b0); end
      begin send(1'b1, CMD_SMUL, 4'hE, 4'hB); repeat (3) send_rand(1'b1); end
    join
    wait_idle();
    check("cont_count", 32'(rsp_log.size()), 32'd8);
    if (rsp_log.size() > 1) begin
      check("cont_rsp0", 32'(rsp_log[0]), 32'({1'b0, 1'b0, 1'b1, 8'h38}));
      check("cont_rsp1", 32'(rsp_log[1]), 32'({1'b1, 1'b0, 1'b1, 8'h0A}));
    end
    for (int k = 0; k < grant_log.size(); k++)
      check($sformatf("rr_grant%0d", k), 32'(grant_log[k]), 32'(k % 2));

    // Backpressure: UCMP 0,0 held in RESP while req0 waits.
    rsp_ready_r = 1'b0;
    send(1'b1, CMD_UCMP, 4'h0, 4'h0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    @(posedge clk); #1;
    s0_done = 0;
    fork
      begin send(1'b0, CMD_XOR, 4'h3, 4'h5); s0_done = 1; end
    join_none
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_result", 32'(bus.rsp_result), 32'd2);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_state", 32'(dbg_state), 32'(ARB_RESP));
    end
    @(posedge clk); #1;
    rsp_ready_r = 1'b1;
    for (int n = 0; n < 20 && !s0_done; n++) @(posedge clk);
    check("bp_regrant_gap", 32'(dut_req_cyc - dut_rsp_cyc), 32'd1);
    wait_idle();

    // Illegal command.
    rsp_log.delete();
    send(1'b0, 4'hE, 4'h5, 4'h6);
    wait_idle();
    check("illegal_count", 32'(rsp_log.size()), 32'd1);
    if (rsp_log.size() > 0) check("illegal_rsp", 32'(rsp_log[0]), 32'({1'b0, 1'b1, 1'b0, 8'h00}));

    // Reset during EXEC.
    send(1'b1, CMD_SADD, 4'h7, 4'h1);
    check("mid_in_exec", 32'(dbg_state), 32'(ARB_EXEC));
    reset_r = 1'b1;
    #1;
    check("mid_state", 32'(dbg_state), 32'(ARB_IDLE));
    check("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rsp_result", 32'(bus.rsp_result), 32'd0);
    check("mid_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("mid_alu_en", 32'(dbg_alu_en), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_r = 1'b0;
    rsp_log.delete();
    grant_log.delete();
    repeat (5) begin
      @(negedge clk);
      check("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    fork
      send(1'b0, CMD_AND, 4'hF, 4'h3);
      send(1'b1, CMD_OR, 4'h1, 4'h2);
    join
    wait_idle();
    check("mid_tie_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() > 0) check("mid_tie_first", 32'(grant_log[0]), 32'd0);
    check("mid_rsp_count", 32'(rsp_log.size()), 32'd2);

    // Randomized traffic with random gaps and downstream stalls.
    rand_done = 0;
    fork
      begin
        fork
          repeat (15) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clk); #1; end
            send_rand(1'b0);
          end
          repeat (15) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send_rand(1'b1);
          end
        join
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          rsp_ready_r = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rsp_ready_r = 1'b1;
    wait_idle();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    check("global_timeout", 32'd0, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance between two requesters.
- Each requester issues {command, a, b} through a valid/ready handshake.
- The block arbitrates round-robin, drives the ALU for one cycle, registers result/overflow and returns them tagged with the requester id on a valid/ready response channel.
- It sits between the instruction-issue logic and the ALU datapath.

Parameters:
- SIZE, 4, operand width in bits; passed straight to the `alu` instance.
- FULL_SIZE, 2*SIZE, result width (localparam, not overridable).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept; at most one bit high per cycle.
- req_cmd0, req_cmd1  in  4  ALU command code per requester.
- req_a0, req_a1  in  SIZE  operand a per requester.
- req_b0, req_b1  in  SIZE  operand b per requester.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accepts response.
- rsp_id  out  1  requester index the response belongs to.
- rsp_result  out  FULL_SIZE  registered ALU result.
- rsp_overflow  out  1  registered ALU overflow.
- rsp_err  out  1  command was illegal (code greater than 4'hC).

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, rr_last=1 so requester 0 wins the first tie.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_overflow=0, rsp_err=0.
  - Latched cmd/a/b/id cleared to 0.
- FSM, three states, encoding from the shared package:
  - IDLE:
    - grant = requester 0 if only req_valid[0]; requester 1 if only req_valid[1].
    - If both are valid, grant the requester not equal to rr_last.
    - req_ready[grant]=1 combinationally in IDLE only.
    - On handshake: latch cmd/a/b/id, set rr_last=id, go to EXEC.
    - With no valid request, stay in IDLE.
  - EXEC, exactly one cycle:
    - alu.enable=1 with the latched cmd/a/b.
    - At cycle end, register result/overflow into the rsp_* registers, set rsp_id, go to RESP.
  - RESP:
    - rsp_valid=1.
    - rsp_result, rsp_overflow, rsp_err and rsp_id stay stable until rsp_ready.
    - On rsp_valid and rsp_ready: rsp_valid=0, go to IDLE.
- Outside EXEC:
  - alu.enable=0.
  - req_ready=0 in EXEC and RESP; requesters must hold their request until accepted.
- Latency:
  - Handshake at cycle T, EXEC at T+1, rsp_valid visible at T+2.
  - With rsp_ready tied high, peak throughput is one op every 3 cycles.
  - Back-to-back: the next grant can occur in the cycle right after the response handshake.
- Illegal command (cmd greater than 4'hC):
  - Accepted normally.
  - In EXEC the ALU stays disabled.
  - Response carries rsp_err=1, rsp_result=0, rsp_overflow=0.
- rsp_err=0 for all legal commands.
- Operand/result widths are passed through unchanged; the block does no arithmetic of its own.
- Stalled response: downstream holding rsp_ready=0 holds the FSM in RESP indefinitely. Pending requests wait; rr_last is unchanged.
- Request deasserted before acceptance: legal, no transaction occurs.
- Reset mid-operation (EXEC or RESP): the in-flight transaction is dropped; no response is produced.
- Round-robin fairness: with both requesters continuously valid, grants alternate 0,1,0,1,...

Decomposition:
- Package alu_pkg:
  - Command constants: CMD_AND=0, CMD_OR=1, CMD_XOR=2, CMD_NOT=3, CMD_UADD=4, CMD_SADD=5, CMD_USUB=6, CMD_SSUB=7, CMD_UMUL=8, CMD_SMUL=9, CMD_UCMP=A, CMD_SCMP=B, CMD_SHIFT=C, CMD_MAX=C.
  - State enum: ARB_IDLE, ARB_EXEC, ARB_RESP.
- One natural sub-module: rr_arbiter2, a 2-way round-robin grant with an rr_last input.
- The existing `alu` is instantiated directly.

Test Plan:
- Single request, SIZE=4: req0 sends AND a=4'hA b=4'h5 with rsp_ready=1.
  - Expect req_ready[0] high one cycle and rsp_valid 2 cycles later.
  - Expect rsp_id=0, rsp_result=0, rsp_overflow=0, rsp_err=0.
- Contention: both requesters valid from reset.
  - req0 UMUL 7,8; req1 SMUL E,B.
  - First response: id=0, result=8'h38, overflow=1.
  - Second response: id=1, result=8'h0A, overflow=1.
  - Then hold both valid: grants alternate 0,1,0,1.
- Backpressure: req1 UCMP 0,0 with rsp_ready=0 for 5 cycles.
  - rsp_valid and result=2 stay stable.
  - req_ready stays 0 although req0 is valid.
  - Release: response completes, next cycle req0 is granted.
- Illegal command: req0 cmd=4'hE.
  - Expect rsp_err=1, result=0, overflow=0.
  - alu.enable stays low throughout.
- Reset mid-op: assert reset asynchronously during EXEC of req1 SADD 7,1.
  - Outputs go to reset values immediately.
  - No response is emitted after release.
  - Next tie goes to requester 0.
